stream_sync_lock_ctrl: RTL and testbench

//  Lock supervisor for the Stream_syncer serial-frame aligner.

---
 rtl/sync_ctrl_pkg.sv | 20 ++
 rtl/frame_watchdog.sv | 35 +++
 rtl/stream_sync_lock_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stream_sync_lock_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sync_ctrl_pkg.sv
// rtl/sync_ctrl_pkg.sv - shared types and default constants for the stream sync lock supervisor
package sync_ctrl_pkg;

    localparam int         WINDOW_SZ = 16;
    localparam int         OUT_SZ    = 8;
    localparam logic [7:0] PATTERN   = 8'hE8;

    typedef enum logic [2:0] {
        HUNT,
        CONFIRM,
        LOCKED,
        FLYWHEEL,
        RESYNC
    } lock_state_t;

    function automatic logic is_locked(input lock_state_t s);
        return (s == LOCKED) || (s == FLYWHEEL);
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// rtl/frame_watchdog.sv - frame-gap watchdog; tmo when LIMIT cycles pass with no clear
module frame_watchdog #(
    parameter int LIMIT = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tmo
);

    localparam int             W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

    logic [W-1:0] wd_q, wd_d;

    // Held at zero while not running so a frozen state can never time out.
    assign tmo = run && (wd_q == LAST);

    always_comb begin
        wd_d = wd_q + W'(1);
        if (!run || clr || tmo) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

endmodule

// File: rtl/stream_sync_lock_ctrl.sv
// rtl/stream_sync_lock_ctrl.sv - hunt/confirm/lock/flywheel supervisor and byte forwarder for Stream_syncer
// Optional stat_frames/stat_losses counters under macro SYNC_LOCK_STATS_EN.
module stream_sync_lock_ctrl #(
    parameter int WINDOW_SZ  = sync_ctrl_pkg::WINDOW_SZ,
    parameter int OUT_SZ     = sync_ctrl_pkg::OUT_SZ,
    parameter int SLACK      = 2,
    parameter int LOCK_CNT   = 3,
    parameter int LOSS_CNT   = 2,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OUT_SZ-1:0] sy_data,
    input  logic              sy_valid,
    input  logic              sy_in_frame,
    output logic              syncer_rst,
    output logic [OUT_SZ-1:0] out_data,
    output logic              out_valid,
    output logic              locked,
    output logic              lock_lost
`ifdef SYNC_LOCK_STATS_EN
    ,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_losses
`endif
);

    import sync_ctrl_pkg::*;

    localparam int            GW        = $clog2(LOCK_CNT + 1);
    localparam int            MW        = $clog2(LOSS_CNT + 1);
    localparam int            RW        = $clog2(RST_CYCLES + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

    lock_state_t       state_q, state_d;
    logic [GW-1:0]     good_cnt_q, good_cnt_d;
    logic [MW-1:0]     miss_cnt_q, miss_cnt_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [OUT_SZ-1:0] out_data_q;
    logic              out_valid_q, locked_q, lock_lost_q, lock_lost_d, syncer_rst_q;
    logic              good, tmo, fwd;

    assign good = sy_valid & sy_in_frame;
    assign fwd  = good & is_locked(state_q);

    frame_watchdog #(
        .LIMIT(WINDOW_SZ + SLACK)
    ) u_wd (
        .clk  (clk),
        .reset(reset),
        .clr  (good || (state_d != state_q)),
        .run  ((state_q != HUNT) && (state_q != RESYNC)),
        .tmo  (tmo)
    );

    // good is always tested ahead of tmo, so a coincident timeout is discarded.
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rst_cnt_d   = '0;
        lock_lost_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (good) begin
                    good_cnt_d = GW'(1);
                    state_d    = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
                end
            end
            CONFIRM: begin
                if (good) begin
                    if (good_cnt_q >= GOOD_LAST - GW'(1)) begin
                        good_cnt_d = GOOD_LAST;
                        state_d    = LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end else if (tmo) begin
                    state_d = RESYNC;
                end
            end
            LOCKED: begin
                if (!good && tmo) begin
                    miss_cnt_d = MW'(1);
                    state_d    = FLYWHEEL;
                end
            end
            FLYWHEEL: begin
                if (good) begin
                    miss_cnt_d = '0;
                    state_d    = LOCKED;
                end else if (tmo) begin
                    if (miss_cnt_q >= MISS_LAST - MW'(1)) begin
                        miss_cnt_d  = MISS_LAST;
                        lock_lost_d = 1'b1;
                        state_d     = RESYNC;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MW'(1);
                    end
                end
            end
            RESYNC: begin
                good_cnt_d = '0;
                miss_cnt_d = '0;
                if (rst_cnt_q >= RST_LAST) begin
                    state_d = HUNT;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            good_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            rst_cnt_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            syncer_rst_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            out_valid_q  <= fwd;
            locked_q     <= is_locked(state_d);
            lock_lost_q  <= lock_lost_d;
            syncer_rst_q <= (state_d == RESYNC);
            if (fwd) begin
                out_data_q <= sy_data;
            end
        end
    end

    assign syncer_rst = syncer_rst_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;

`ifdef SYNC_LOCK_STATS_EN
    logic [15:0] stat_frames_q, stat_losses_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames_q <= '0;
            stat_losses_q <= '0;
        end else begin
            if (fwd && (stat_frames_q != 16'hFFFF)) begin
                stat_frames_q <= stat_frames_q + 16'd1;
            end
            if (lock_lost_d && (stat_losses_q != 16'hFFFF)) begin
                stat_losses_q <= stat_losses_q + 16'd1;
            end
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_losses = stat_losses_q;
`endif

endmodule

// File: tb/tb_stream_sync_lock_ctrl.sv
// tb/tb_stream_sync_lock_ctrl.sv - scoreboard bench for stream_sync_lock_ctrl
module tb_stream_sync_lock_ctrl;

    import sync_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sy_data = '0;
    logic       sy_valid = 1'b0;
    logic       sy_in_frame = 1'b0;
    logic       syncer_rst, out_valid, locked, lock_lost;
    logic [7:0] out_data;
`ifdef SYNC_LOCK_STATS_EN
    logic [15:0] stat_frames, stat_losses;
`endif

    stream_sync_lock_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sy_data    (sy_data),
        .sy_valid   (sy_valid),
        .sy_in_frame(sy_in_frame),
        .syncer_rst (syncer_rst),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .locked     (locked),
        .lock_lost  (lock_lost)
`ifdef SYNC_LOCK_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_losses(stat_losses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_fwd = 0;
    int   n_lost = 0;
    int   last_good = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (!reset && lock_lost) n_lost++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic in_frame, input logic fwd);
        exp_t e;
        sy_data     = d;
        sy_valid    = 1'b1;
        sy_in_frame = in_frame;
        if (fwd) begin
            e.data = d;
            e.cyc  = cyc + 1;
            sb.push_back(e);
            n_fwd++;
        end
        tick();
        if (in_frame) last_good = cyc;
        sy_valid    = 1'b0;
        sy_in_frame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit found;
        gap(3);
        check("rst_syncer_rst", 32'(syncer_rst), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(HUNT));
        reset = 1'b0;
        gap(2);

        // Acquire: only the byte after lock is forwarded.
        send(8'h11, 1'b1, 1'b0);
        gap(15);
        send(8'h22, 1'b1, 1'b0);
        check("confirm_state", 32'(dut.state_q), 32'(CONFIRM));
        check("confirm_locked", 32'(locked), 32'd0);
        gap(15);
        send(8'h33, 1'b1, 1'b0);
        check("lock_rise", 32'(locked), 32'd1);
        gap(15);
        send(8'h44, 1'b1, 1'b1);
        gap(15);

        // Flywheel over one dropped byte.
        gap(16);
        check("fly_state", 32'(dut.state_q), 32'(FLYWHEEL));
        check("fly_locked", 32'(locked), 32'd1);
        send(8'h55, 1'b1, 1'b1);
        check("relock_state", 32'(dut.state_q), 32'(LOCKED));

        // Out-of-frame valid is ignored mid-frame.
        gap(7);
        send(8'h99, 1'b0, 1'b0);
        gap(7);
        send(8'h66, 1'b1, 1'b1);

        // Good coincident with the flywheel timeout.
        gap(35);
        send(8'h88, 1'b1, 1'b1);
        check("coinc_state", 32'(dut.state_q), 32'(LOCKED));
        check("coinc_miss", 32'(dut.miss_cnt_q), 32'd0);
        check("coinc_no_loss", 32'(n_lost), 32'd0);

        // Loss: silence after the last good.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (lock_lost) found = 1'b1;
        end
        if (!found) check("loss_timeout", 32'd0, 32'd1);
        check("loss_latency", 32'(cyc - last_good), 32'd36);
        check("loss_syncer_rst1", 32'(syncer_rst), 32'd1);
        check("loss_locked", 32'(locked), 32'd0);
        tick();
        check("loss_pulse_width", 32'(lock_lost), 32'd0);
        check("loss_syncer_rst2", 32'(syncer_rst), 32'd1);
        tick();
        check("loss_syncer_rst_end", 32'(syncer_rst), 32'd0);
        check("loss_state_hunt", 32'(dut.state_q), 32'(HUNT));
`ifdef SYNC_LOCK_STATS_EN
        check("stat_frames", 32'(stat_frames), 32'(n_fwd));
        check("stat_losses", 32'(stat_losses), 32'(n_lost));
`endif
        gap(3);

        // Confirm failure, then async reset inside the syncer_rst pulse.
        send(8'hA1, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (syncer_rst) found = 1'b1;
        end
        if (!found) check("confirm_fail_timeout", 32'd0, 32'd1);
        check("confirm_fail_latency", 32'(cyc - last_good), 32'd18);
        #2;
        reset = 1'b1;
        #1;
        check("async_abort_rst", 32'(syncer_rst), 32'd0);
        check("async_abort_state", 32'(dut.state_q), 32'(HUNT));
        tick();
        reset = 1'b0;
        gap(2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
